csa_serial_adder: RTL and testbench

- Sequential wide adder that adds two NBYTES-byte operands one byte per cycle, LSB byte first.
- Each byte is computed with the existing 8-bit carry-select adder (csa_8). Carry is chained between bytes through a register.
- Acts as the control/sequencing stage around csa_8. It feeds csa_8 byte slices and consumes its sum/carry to build wide results cheaply in area.
- Valid/ready handshake on both input and output sides.

---
 rtl/csa_pkg.sv | 16 +
 rtl/csa_8.sv | 31 +++
 rtl/csa_serial_adder.sv | 131 +++++++++++++
 tb/tb_csa_serial_adder.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared types and constants for the carry-select serial adder slice.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package csa_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/csa_8.sv
// 8-bit carry-select adder: nibble ripple low half, upper half precomputed for both carries.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module csa_8
    import csa_pkg::*;
(
    input  byte_t a,
    input  byte_t b,
    output byte_t sum,
    output logic  cout
);

    logic [4:0] lo_sum;
    logic [4:0] hi_sum0;
    logic [4:0] hi_sum1;

    // Low nibble adds directly; high nibble is computed for carry-in 0 and 1, then selected.
    always_comb begin
        lo_sum  = {1'b0, a[3:0]} + {1'b0, b[3:0]};
        hi_sum0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
        hi_sum1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;
        if (lo_sum[4]) begin
            sum  = {hi_sum1[3:0], lo_sum[3:0]};
            cout = hi_sum1[4];
        end else begin
            sum  = {hi_sum0[3:0], lo_sum[3:0]};
            cout = hi_sum0[4];
        end
    end

endmodule

// File: rtl/csa_serial_adder.sv
// Wide unsigned adder processing one byte per cycle (LSB first) through two csa_8 instances.
// Latency: pair accepted at edge E, result valid right after edge E+NBYTES.
// Backpressure: result held in DONE until out_ready; no new pair accepted until back in IDLE.
module csa_serial_adder
    import csa_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] a,
    input  logic [BYTE_W*NBYTES-1:0] b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] sum,
    output logic                     carry_out
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;

    byte_t a_byte;
    byte_t b_byte;
    byte_t s1;
    byte_t s2;
    logic  c1;
    logic  c2;

    // Current byte slice of each captured operand.
    always_comb begin
        a_byte = a_q[BYTE_W*cnt_q +: BYTE_W];
        b_byte = b_q[BYTE_W*cnt_q +: BYTE_W];
    end

    csa_8 u_add_op (
        .a    (a_byte),
        .b    (b_byte),
        .sum  (s1),
        .cout (c1)
    );

    // The chained carry enters as a zero-extended byte; c1 and c2 can never both be set.
    csa_8 u_add_cin (
        .a    (s1),
        .b    ({{(BYTE_W-1){1'b0}}, carry_q}),
        .sum  (s2),
        .cout (c2)
    );

    // Next-state and datapath updates for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sum_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[BYTE_W*cnt_q +: BYTE_W] = s2;
                carry_d = c1 | c2;
                if (cnt_q == CNT_LAST) begin
                    cout_d  = c1 | c2;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Handshake flags decode straight from the state register.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        sum       = sum_q;
        carry_out = cout_q;
    end

endmodule

// File: tb/tb_csa_serial_adder.sv
// Randomized and directed check of csa_serial_adder against plain wide arithmetic.
// Latency: checks result appears exactly after edge E+NBYTES.
// Backpressure: holds out_ready low for varying lengths and scrambles inputs meanwhile.
module tb_csa_serial_adder;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;

    int n_chk;
    int n_fail;

    csa_serial_adder #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One full transaction: accept, wait the fixed latency, check, hold, release.
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input int hold,
                         input string tag);
        logic [W:0] exp;
        exp = {1'b0, oa} + {1'b0, ob};
        chk({tag, "/idle_ready"}, 64'(in_ready), 64'd1);
        a        = oa;
        b        = ob;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        chk({tag, "/run_ready"}, 64'(in_ready), 64'd0);
        for (int k = 1; k < NBYTES; k++) begin
            @(negedge clk);
            chk({tag, "/early_valid"}, 64'(out_valid), 64'd0);
        end
        @(negedge clk);
        chk({tag, "/valid"}, 64'(out_valid), 64'd1);
        chk({tag, "/sum"}, 64'(sum), 64'(exp[W-1:0]));
        chk({tag, "/cout"}, 64'(carry_out), 64'(exp[W]));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            a        = $urandom;
            b        = $urandom;
            @(negedge clk);
            chk({tag, "/hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "/hold_ready"}, 64'(in_ready), 64'd0);
            chk({tag, "/hold_sum"}, {31'd0, carry_out, sum}, {31'd0, exp});
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, "/drop_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "/back_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "/kept_sum"}, {31'd0, carry_out, sum}, {31'd0, exp});
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #12;
        chk("rst/in_ready", 64'(in_ready), 64'd1);
        chk("rst/out_valid", 64'(out_valid), 64'd0);
        chk("rst/sum", 64'(sum), 64'd0);
        chk("rst/cout", 64'(carry_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(32'h0000_0005, 32'h0000_0003, 0, "d5p3");
        do_op(32'h0000_00FF, 32'h0000_0001, 1, "ripple1");
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 2, "ovf");
        do_op(32'hC3C3_C3C3, 32'hE8E8_E8E8, 0, "c3e8");
        do_op(32'h1234_5678, 32'h1111_1111, 6, "bp");

        // Abort two cycles into RUN.
        a        = 32'h1234_5678;
        b        = 32'h8765_4321;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort/out_valid", 64'(out_valid), 64'd0);
        chk("abort/in_ready", 64'(in_ready), 64'd1);
        chk("abort/sum", 64'(sum), 64'd0);
        chk("abort/cout", 64'(carry_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(32'h0000_0001, 32'h0000_0002, 0, "post_rst");

        for (int i = 0; i < 25; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 0) ra = ~rb;
            do_op(ra, rb, int'($urandom_range(0, 3)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
